// File: rtl/calc2.sv
// rtl/calc2.sv - multi-port two-operand calculator sharing one ALU behind a round-robin arbiter
// Each port collects cmd+operand1, then operand2, then waits in PEND until granted the ALU.
module calc2 #(
  parameter int NPORTS   = 4,
  parameter int DW       = 32,
  parameter int SATURATE = 0
) (
  input  logic                 c_clk,
  input  logic                 reset,
  input  logic [4*NPORTS-1:0]  req_cmd_in,
  input  logic [DW*NPORTS-1:0] req_data_in,
  output logic [DW*NPORTS-1:0] out_data,
  output logic [2*NPORTS-1:0]  out_resp,
  output logic [NPORTS-1:0]    out_busy
);

  localparam int SW = $clog2(DW);
  localparam int LW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state_q [NPORTS];
  state_t          state_d [NPORTS];
  logic [3:0]      cmd_q   [NPORTS];
  logic [3:0]      cmd_d   [NPORTS];
  logic [DW-1:0]   op1_q   [NPORTS];
  logic [DW-1:0]   op1_d   [NPORTS];
  logic [DW-1:0]   op2_q   [NPORTS];
  logic [DW-1:0]   op2_d   [NPORTS];
  logic [LW-1:0]   last_q, last_d;
  logic [DW*NPORTS-1:0] out_data_q, out_data_d;
  logic [2*NPORTS-1:0]  out_resp_q, out_resp_d;

  logic            gnt_vld;
  logic [LW-1:0]   gnt_idx;
  int              search_idx;

  logic [3:0]      alu_cmd;
  logic [DW-1:0]   alu_a, alu_b;
  logic [DW:0]     alu_sum;
  logic [DW-1:0]   res_data;
  logic [1:0]      res_resp;

  // Round-robin: first PEND port found starting just after the last grant.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    search_idx = 0;
    for (int i = 0; i < NPORTS; i++) begin
      search_idx = (int'(last_q) + 1 + i) % NPORTS;
      if (!gnt_vld && state_q[search_idx] == PEND) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'(search_idx);
      end
    end
  end

  always_comb begin
    alu_cmd  = cmd_q[gnt_idx];
    alu_a    = op1_q[gnt_idx];
    alu_b    = op2_q[gnt_idx];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    res_data = '0;
    res_resp = RESP_ERR;
    case (alu_cmd)
      CMD_ADD: begin
        if (alu_sum[DW]) begin
          res_resp = RESP_ERR;
          res_data = (SATURATE != 0) ? '1 : '0;
        end else begin
          res_resp = RESP_OK;
          res_data = alu_sum[DW-1:0];
        end
      end
      CMD_SUB: begin
        if (alu_a < alu_b) begin
          res_resp = RESP_ERR;
          res_data = '0;
        end else begin
          res_resp = RESP_OK;
          res_data = alu_a - alu_b;
        end
      end
      CMD_SHL: begin
        res_resp = RESP_OK;
        res_data = alu_a << alu_b[SW-1:0];
      end
      CMD_SHR: begin
        res_resp = RESP_OK;
        res_data = alu_a >> alu_b[SW-1:0];
      end
      default: begin
        res_resp = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      state_d[k] = state_q[k];
      cmd_d[k]   = cmd_q[k];
      op1_d[k]   = op1_q[k];
      op2_d[k]   = op2_q[k];
      case (state_q[k])
        IDLE: begin
          if (req_cmd_in[4*k +: 4] != 4'd0) begin
            cmd_d[k]   = req_cmd_in[4*k +: 4];
            op1_d[k]   = req_data_in[DW*k +: DW];
            state_d[k] = OP2;
          end
        end
        OP2: begin
          op2_d[k]   = req_data_in[DW*k +: DW];
          state_d[k] = PEND;
        end
        PEND: begin
          if (gnt_vld && gnt_idx == LW'(k)) state_d[k] = IDLE;
        end
        default: state_d[k] = IDLE;
      endcase
    end

    out_data_d = '0;
    out_resp_d = {NPORTS{RESP_NONE}};
    last_d     = last_q;
    if (gnt_vld) begin
      out_data_d[DW*gnt_idx +: DW] = res_data;
      out_resp_d[2*gnt_idx +: 2]   = res_resp;
      last_d                       = gnt_idx;
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      for (int k = 0; k < NPORTS; k++) begin
        state_q[k] <= IDLE;
        cmd_q[k]   <= '0;
        op1_q[k]   <= '0;
        op2_q[k]   <= '0;
      end
      last_q     <= LW'(NPORTS - 1);
      out_data_q <= '0;
      out_resp_q <= '0;
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        state_q[k] <= state_d[k];
        cmd_q[k]   <= cmd_d[k];
        op1_q[k]   <= op1_d[k];
        op2_q[k]   <= op2_d[k];
      end
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_resp_q <= out_resp_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NPORTS; k++) out_busy[k] = (state_q[k] != IDLE);
  end

  assign out_data = out_data_q;
  assign out_resp = out_resp_q;

endmodule

// File: doc/calc2.md
CALC2 -- requirements
Module: calc2

Interface
REQ-001 SHALL have parameter NPORTS, default 4: number of request ports; legal range 1..8.
REQ-002 SHALL have parameter DW, default 32: operand/result width; legal values 8, 16, 32, 64.
REQ-003 SHALL have parameter SATURATE, default 0: selects overflow/underflow data policy (REQ-018).
REQ-004 SHALL have port c_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_cmd_in  input  4*NPORTS  per-port command; port k at bits [4k+3:4k].
REQ-007 SHALL have port req_data_in  input  DW*NPORTS  per-port operand; port k at [DW*k+DW-1:DW*k].
REQ-008 SHALL have port out_data  output  DW*NPORTS  per-port result, same slicing as req_data_in.
REQ-009 SHALL have port out_resp  output  2*NPORTS  per-port response: 0 none, 1 success, 2 error; 3 never driven.
REQ-010 SHALL have port out_busy  output  NPORTS  bit k high while port k is not IDLE.

Function
REQ-011 SHALL decode commands: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; all other non-zero values invalid.
REQ-012 SHALL run a per-port FSM IDLE -> OP2 -> PEND -> IDLE; no other states.
REQ-013 IDLE: non-zero cmd sampled -> latch cmd and data as operand1, go to OP2; cmd 0 -> stay IDLE.
REQ-014 OP2: sample data as operand2 regardless of cmd, go to PEND; cmd input ignored in OP2.
REQ-015 PEND: cmd input ignored (dropped, no response); leave PEND only on the edge the port is granted.
REQ-016 SHALL use one shared ALU; a round-robin arbiter grants at most one PEND port per edge, searching from (last granted + 1) mod NPORTS.
REQ-017 Add/sub SHALL be unsigned DW-bit: add carry-out = overflow; sub with operand1 < operand2 = underflow.
REQ-018 Overflow/underflow: SATURATE=0 -> resp 2, data 0; SATURATE=1 -> resp 2, data all-ones (add) or 0 (sub).
REQ-019 Shifts SHALL be logical with amount = operand2[log2(DW)-1:0]; upper operand2 bits ignored; resp 1 always.
REQ-020 Invalid command SHALL complete the full IDLE->OP2->PEND flow and return resp 2, data 0.
REQ-021 Result SHALL be registered into the granted port's out_data/out_resp on the grant edge and held exactly one cycle; otherwise out_resp=0 and out_data=0.
REQ-022 Uncontended latency: cmd in cycle N, operand2 in N+1, response visible in N+3; each competing PEND port adds at most 1 cycle, worst case N+2+NPORTS.
REQ-023 Port returns to IDLE on its grant edge; a new cmd may be presented in its response cycle.
REQ-024 Ports SHALL be independent; one port's state never affects another's operands or results.

Reset
REQ-025 reset=0 at a rising edge SHALL force all ports to IDLE, out_data=0, out_resp=0, out_busy=0, arbiter last-granted=NPORTS-1 (port 0 highest priority first).
REQ-026 Requests in OP2 or PEND at reset SHALL be discarded with no response; inputs ignored while reset=0.

Verification
REQ-027 Port 0 cmd 1 data 0x00000001, then data 0x1FFFFFFF -> cycle N+3: out_resp[0]=1, out_data[0]=0x20000000; cycle N+4: resp 0, data 0.
REQ-028 Port 1 add 0xFFFFFFFF + 1 -> resp 2, data 0 (SATURATE=0) / 0xFFFFFFFF (SATURATE=1); port 2 sub 0x1 - 0xF -> resp 2, data 0.
REQ-029 Port 0 shl 0x1 by 31 -> 0x80000000 resp 1; shr 0x80000000 by 0x21 (amount 1) -> 0x40000000 resp 1; cmd 3 and cmd 4 -> resp 2, data 0.
REQ-030 All 4 ports issue add 1+1 in same cycle N after reset -> resp 1 data 2 on ports 0,1,2,3 in cycles N+3,N+4,N+5,N+6; repeat -> same order.
REQ-031 Port 0 cmd 1 while in PEND (contended by ports 1-3 granted first in a rotated round) -> only the original request answered, no extra response.
REQ-032 reset=0 in cycle N+2 of a pending add -> no response; all outputs 0 from cycle N+3; new cmd after release completes normally.
